aes_core_arbiter: RTL and testbench

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

---
 rtl/aes_core_arbiter.sv | 154 +++++++++++++++
 tb/tb_aes_core_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// Two-port front end that shares a single aes_top core; one command in flight at a time.
// Define AES_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
`timescale 1ns/1ps

`ifndef WORD_S
`define WORD_S [31:0]
`endif
`ifndef KEY_S
`define KEY_S [127:0]
`endif
`ifndef BLK_S
`define BLK_S [127:0]
`endif
`ifndef ENCRYPT
`define ENCRYPT 32'h0000_0001
`endif
`ifndef SET_KEY
`define SET_KEY 32'h0000_0002
`endif

module aes_core_arbiter #(
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic `WORD_S req0_cmd,
  input  logic `KEY_S  req0_key,
  input  logic `BLK_S  req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic `WORD_S req1_cmd,
  input  logic `KEY_S  req1_key,
  input  logic `BLK_S  req1_data,
  output logic         rsp0_valid,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  output logic         rsp1_err,
  output logic `BLK_S  rsp_data,
  output logic         core_en,
  output logic `WORD_S core_cmd,
  output logic `KEY_S  core_key,
  output logic `BLK_S  core_plaintext,
  input  logic `BLK_S  core_ciphertext,
  input  logic         core_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(BUSY_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        grant;
  logic        sel0, sel1;
  logic        accept;
  logic        timeout;
  logic        done_ok;
  logic        rsp_err_q;
  logic [15:0] wait_cnt;
  logic `WORD_S cmd_sel;
  logic `KEY_S  key_sel;
  logic `BLK_S  data_sel;
`ifdef AES_ARB_ROUND_ROBIN_EN
  logic        last_grant;
`endif

  // Contention goes to the port that did not win last time.
  always_comb begin
`ifdef AES_ARB_ROUND_ROBIN_EN
    sel0 = req0_valid && (!req1_valid || last_grant);
    sel1 = req1_valid && (!req0_valid || !last_grant);
`else
    sel0 = req0_valid;
    sel1 = req1_valid && !req0_valid;
`endif
    req0_ready = (state == IDLE) && !reset && sel0;
    req1_ready = (state == IDLE) && !reset && sel1;
  end

  always_comb begin
    cmd_sel  = req1_ready ? req1_cmd  : req0_cmd;
    key_sel  = req1_ready ? req1_key  : req0_key;
    data_sel = req1_ready ? req1_data : req0_data;
  end

  assign accept  = req0_ready || req1_ready;
  assign done_ok = (state == WAIT) && core_done;
  assign timeout = (state == WAIT) && (wait_cnt == TIMEOUT_LAST);

  always_comb begin
    state_nxt  = state;
    core_en    = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_err   = 1'b0;
    rsp1_err   = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        core_en   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (done_ok || timeout) state_nxt = RESP;
      RESP: begin
        rsp0_valid = !grant;
        rsp1_valid = grant;
        rsp0_err   = !grant && rsp_err_q;
        rsp1_err   = grant && rsp_err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= 1'b0;
      wait_cnt       <= '0;
      rsp_err_q      <= 1'b0;
      rsp_data       <= '0;
      core_cmd       <= '0;
      core_key       <= '0;
      core_plaintext <= '0;
`ifdef AES_ARB_ROUND_ROBIN_EN
      last_grant     <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      // Only the operand relevant to the command reaches the core; the other is zeroed.
      if (accept) begin
        grant          <= req1_ready;
        core_cmd       <= cmd_sel;
        core_key       <= (cmd_sel == `SET_KEY) ? key_sel : '0;
        core_plaintext <= (cmd_sel == `ENCRYPT) ? data_sel : '0;
`ifdef AES_ARB_ROUND_ROBIN_EN
        last_grant     <= req1_ready;
`endif
      end
      // A done arriving on the timeout cycle still wins.
      if (done_ok || timeout) begin
        rsp_data       <= done_ok ? core_ciphertext : '0;
        rsp_err_q      <= !done_ok;
        core_cmd       <= '0;
        core_key       <= '0;
        core_plaintext <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: transaction-level scoreboard plus directed scenarios with literal expectations.
`timescale 1ns/1ps

`ifndef WORD_S
`define WORD_S [31:0]
`endif
`ifndef KEY_S
`define KEY_S [127:0]
`endif
`ifndef BLK_S
`define BLK_S [127:0]
`endif
`ifndef ENCRYPT
`define ENCRYPT 32'h0000_0001
`endif
`ifndef SET_KEY
`define SET_KEY 32'h0000_0002
`endif

module tb_aes_core_arbiter;

  localparam int BT = 20;
  localparam int CORE_LAT = 12;
  localparam logic `WORD_S ENC = `ENCRYPT;
  localparam logic `WORD_S SK  = `SET_KEY;

  typedef struct {
    logic `WORD_S cmd;
    logic `KEY_S  key;
    logic `BLK_S  data;
  } req_t;

  typedef struct {
    logic        port;
    logic        err;
    logic `BLK_S data;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] v, rdy, rv, re;
  logic `WORD_S c [2];
  logic `KEY_S  k [2];
  logic `BLK_S  d [2];
  logic `BLK_S  rsp_data;
  logic         core_en;
  logic `WORD_S core_cmd;
  logic `KEY_S  core_key;
  logic `BLK_S  core_pt;
  logic `BLK_S  core_ct;
  logic         core_done;

  logic wd1, spur, dead;
  req_t q0[$], q1[$];
  rsp_t rlog[$];
  int checks = 0;
  int errors = 0;
  int en_count = 0;

  aes_core_arbiter #(.BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_ready(rdy[0]), .req0_cmd(c[0]), .req0_key(k[0]), .req0_data(d[0]),
    .req1_valid(v[1]), .req1_ready(rdy[1]), .req1_cmd(c[1]), .req1_key(k[1]), .req1_data(d[1]),
    .rsp0_valid(rv[0]), .rsp0_err(re[0]), .rsp1_valid(rv[1]), .rsp1_err(re[1]),
    .rsp_data(rsp_data),
    .core_en(core_en), .core_cmd(core_cmd), .core_key(core_key), .core_plaintext(core_pt),
    .core_ciphertext(core_ct), .core_done(core_done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Core stand-in: done 12 cycles after core_en, ciphertext = plaintext ^ key register.
  initial begin : core_model
    int cd;
    logic `KEY_S kreg;
    logic `BLK_S ptreg;
    cd = 0; kreg = '0; ptreg = '0;
    core_done = 1'b0;
    core_ct = '0;
    forever begin
      @(posedge clk); #1;
      core_done = spur;
      if (spur) core_ct = {4{32'h0badf00d}};
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !dead) begin
          core_done = 1'b1;
          core_ct = ptreg ^ kreg;
        end
      end
      if (core_en) begin
        cd = CORE_LAT;
        if (core_cmd == SK) kreg = core_key;
        ptreg = core_pt;
      end
    end
  end

  // Requesters: present the head of each queue, hold until handshake, then advance.
  initial begin : requesters
    logic hs0, hs1;
    v = '0;
    for (int i = 0; i < 2; i++) begin c[i] = '0; k[i] = '0; d[i] = '0; end
    forever begin
      @(negedge clk);
      hs0 = v[0] && rdy[0];
      hs1 = v[1] && rdy[1];
      @(posedge clk); #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        v[0] = 1'b1; c[0] = q0[0].cmd; k[0] = q0[0].key; d[0] = q0[0].data;
      end else v[0] = 1'b0;
      if (q1.size() > 0) begin
        v[1] = 1'b1; c[1] = q1[0].cmd; k[1] = q1[0].key; d[1] = q1[0].data;
      end else if (wd1) begin
        v[1] = 1'b1; c[1] = ENC; k[1] = '1; d[1] = {4{32'hcafef00d}};
      end else v[1] = 1'b0;
    end
  end

  // Transaction-level model: one command at a time, response 14 cycles after
  // acceptance on success or BT+2 cycles on timeout.
  int          cyc = 0;
  bit          started = 0, post_rst = 0, m_busy = 0, m_dead = 0;
  logic        m_port = 1'b0, m_last = 1'b1, e0, e1, hit;
  int          m_t = 0, m_resp = 0;
  req_t        m_req;
  logic `KEY_S m_key = '0;
  logic `BLK_S m_exp = '0, pt_eff;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (started) begin
        chk1("ready0_in_reset", rdy[0], 1'b0);
        chk1("ready1_in_reset", rdy[1], 1'b0);
      end
      started = 1; post_rst = 1; m_busy = 0; m_last = 1'b1;
    end else if (started) begin
      if (post_rst) begin
        chkw("core_cmd_after_reset", 128'(core_cmd), '0);
        chkw("core_key_after_reset", core_key, '0);
        chkw("core_pt_after_reset", core_pt, '0);
        chkw("rsp_data_after_reset", rsp_data, '0);
        post_rst = 0;
      end
      e0 = 1'b0; e1 = 1'b0;
      if (!m_busy) begin
        if (v[0] && v[1]) begin
`ifdef AES_ARB_ROUND_ROBIN_EN
          if (m_last) e0 = 1'b1; else e1 = 1'b1;
`else
          e0 = 1'b1;
`endif
        end else begin
          e0 = v[0]; e1 = v[1];
        end
      end
      chk1("ready0", rdy[0], e0);
      chk1("ready1", rdy[1], e1);
      chk1("core_en", core_en, m_busy && cyc == m_t + 1);
      if (core_en) en_count++;
      if (m_busy && cyc > m_t && cyc < m_resp) begin
        chkw("core_cmd", 128'(core_cmd), 128'(m_req.cmd));
        chkw("core_key", core_key, (m_req.cmd == SK) ? m_req.key : '0);
        chkw("core_pt", core_pt, (m_req.cmd == ENC) ? m_req.data : '0);
      end
      hit = m_busy && cyc == m_resp;
      chk1("rsp0_valid", rv[0], hit && !m_port);
      chk1("rsp1_valid", rv[1], hit && m_port);
      if (rv != 2'b00) rlog.push_back('{port: rv[1], err: rv[1] ? re[1] : re[0], data: rsp_data, cyc: cyc});
      if (hit) begin
        chk1("rsp_err", m_port ? re[1] : re[0], m_dead);
        chkw("rsp_data", rsp_data, m_exp);
        m_busy = 0;
      end else if (e0 || e1) begin
        m_busy = 1; m_port = e1; m_last = e1; m_t = cyc; m_dead = dead;
        m_req = '{cmd: c[e1], key: k[e1], data: d[e1]};
        m_resp = m_t + (m_dead ? BT + 2 : CORE_LAT + 2);
        pt_eff = (m_req.cmd == ENC) ? m_req.data : '0;
        if (m_req.cmd == SK) m_key = m_req.key;
        m_exp = m_dead ? '0 : (pt_eff ^ m_key);
      end
    end
  end

  task automatic push(input int n, input logic `WORD_S cmd, input logic `KEY_S key, input logic `BLK_S data);
    req_t r;
    r = '{cmd: cmd, key: key, data: data};
    if (n == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_rsp(input int n, input int budget, input string nm);
    int i;
    i = 0;
    while (rlog.size() < n && i < budget) begin @(negedge clk); #1; i++; end
    chk1(nm, rlog.size() >= n, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin : stimulus
    int n, en0, cnt;
    logic exp_order [3];
    reset = 1'b1; wd1 = 1'b0; spur = 1'b0; dead = 1'b0;
    idle(2);
    chk1("rst_ready0", rdy[0], 1'b0);
    chk1("rst_core_en", core_en, 1'b0);
    chk1("rst_rsp0_valid", rv[0], 1'b0);
    chk1("rst_rsp1_err", re[1], 1'b0);
    chkw("rst_rsp_data", rsp_data, '0);
    chkw("rst_core_cmd", 128'(core_cmd), '0);
    @(posedge clk); #1 reset = 1'b0;

    // SET_KEY then ENCRYPT from port 0
    idle(2);
    n = rlog.size(); en0 = en_count;
    push(0, SK, 128'h000102030405060708090a0b0c0d0e0f, {4{32'h5a5a5a5a}});
    push(0, ENC, {4{32'hdeadbeef}}, 128'h00112233445566778899aabbccddeeff);
    wait_rsp(n + 2, 60, "t1_two_responses");
    chk1("t1_port_a", rlog[n].port, 1'b0);
    chk1("t1_port_b", rlog[n+1].port, 1'b0);
    chk1("t1_err", rlog[n+1].err, 1'b0);
    chkw("t1_ciphertext", rlog[n+1].data, 128'h00102030405060708090a0b0c0d0e0f0);
    chkw("t1_core_en_pulses", 128'(en_count - en0), 128'd2);

    // Contention after reset, port 0 re-requesting while port 1 waits
    do_reset();
    idle(1);
    n = rlog.size();
    push(0, ENC, {4{32'h11111111}}, {4{32'h01010101}});
    push(1, ENC, '0, {4{32'h02020202}});
    push(0, ENC, '0, {4{32'h03030303}});
    wait_rsp(n + 3, 80, "t2_three_responses");
`ifdef AES_ARB_ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b0, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 3; i++) chk1($sformatf("t2_order_%0d", i), rlog[n+i].port, exp_order[i]);

    // Spurious done while idle, then a port-1 request withdrawn before it is served
    idle(2);
    n = rlog.size(); en0 = en_count;
    @(negedge clk); #1 spur = 1'b1;
    @(negedge clk); #1 spur = 1'b0;
    idle(3);
    chkw("t3_no_rsp_on_spurious_done", 128'(rlog.size()), 128'(n));
    chkw("t3_no_core_en_on_spurious_done", 128'(en_count), 128'(en0));
    push(0, ENC, '0, {4{32'h0f0f0f0f}});
    idle(3);
    wd1 = 1'b1;
    idle(4);
    wd1 = 1'b0;
    wait_rsp(n + 1, 40, "t3_port0_response");
    idle(4);
    chkw("t3_single_response", 128'(rlog.size()), 128'(n + 1));
    chk1("t3_response_port", rlog[n].port, 1'b0);
    chkw("t3_single_core_en", 128'(en_count - en0), 128'd1);

    // Core never answers: timeout, then a normal request
    n = rlog.size();
    dead = 1'b1;
    push(0, ENC, '0, {4{32'h77777777}});
    wait_rsp(n + 1, 50, "t4_timeout_response");
    dead = 1'b0;
    chk1("t4_err", rlog[n].err, 1'b1);
    chkw("t4_data_zero", rlog[n].data, '0);
    push(1, ENC, '0, {4{32'h12345678}});
    wait_rsp(n + 2, 40, "t4_next_response");
    chk1("t4_next_err", rlog[n+1].err, 1'b0);
    chk1("t4_next_port", rlog[n+1].port, 1'b1);

    // Reset in the middle of WAIT, late core_done must be ignored
    idle(2);
    n = rlog.size(); en0 = en_count;
    push(0, ENC, '0, {4{32'h99999999}});
    cnt = 0;
    while (en_count == en0 && cnt < 10) begin idle(1); cnt++; end
    chk1("t5_issued", en_count > en0, 1'b1);
    idle(6);
    do_reset();
    idle(14);
    chkw("t5_no_rsp_after_reset", 128'(rlog.size()), 128'(n));
    push(0, ENC, '0, {4{32'h44444444}});
    push(1, ENC, '0, {4{32'h55555555}});
    wait_rsp(n + 2, 60, "t5_post_reset_responses");
    chk1("t5_first_port", rlog[n].port, 1'b0);
    chk1("t5_second_port", rlog[n+1].port, 1'b1);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
